// File: rtl/mmss_bcd_counter.sv
// rtl/mmss_bcd_counter.sv - MM:SS BCD up/down timer core with run/stop/done control
// Define TIMER_ALARM_EN to enable the alarm pulse-train window after expiry.
module mmss_bcd_counter #(
    parameter int MIN_MAX     = 59,
    parameter int ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       mode,
    input  logic       clr,
    input  logic       start_stop,
    input  logic       inc_min,
    input  logic       inc_sec,
    output logic [3:0] m10,
    output logic [3:0] m1,
    output logic [3:0] s10,
    output logic [3:0] s1,
    output logic       running,
    output logic       done,
    output logic       alarm
);
    typedef enum logic [1:0] {ST_STOPPED, ST_RUN, ST_DONE} state_t;

    localparam logic [3:0] MAX_M10 = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_M1  = 4'(MIN_MAX % 10);

    state_t     state_q, state_d;
    logic [3:0] m10_q, m1_q, s10_q, s1_q;
    logic [3:0] m10_d, m1_d, s10_d, s1_d;
    logic       running_q, done_q;
    logic       armed_q;
    logic       clr_prev_q, ss_prev_q, imin_prev_q, isec_prev_q;
    logic       clr_ev, ss_ev, imin_ev, isec_ev;
    logic [7:0] sec_up, sec_dn, min_up, min_dn;
    logic       sec_wrap, sec_zero, min_zero, min_at_max;
    logic       cnt_zero, cnt_one, cnt_max;

    // armed_q masks the first cycle after reset so a button held through release is not an edge
    assign clr_ev  = armed_q & clr        & ~clr_prev_q;
    assign ss_ev   = armed_q & start_stop & ~ss_prev_q;
    assign imin_ev = armed_q & inc_min    & ~imin_prev_q;
    assign isec_ev = armed_q & inc_sec    & ~isec_prev_q;

    assign sec_zero   = (s10_q == 4'd0) && (s1_q == 4'd0);
    assign sec_wrap   = (s10_q == 4'd5) && (s1_q == 4'd9);
    assign min_zero   = (m10_q == 4'd0) && (m1_q == 4'd0);
    assign min_at_max = (m10_q == MAX_M10) && (m1_q == MAX_M1);
    assign cnt_zero   = min_zero && sec_zero;
    assign cnt_one    = min_zero && (s10_q == 4'd0) && (s1_q == 4'd1);
    assign cnt_max    = min_at_max && sec_wrap;

    assign sec_up = sec_wrap ? 8'h00 : (s1_q == 4'd9) ? {s10_q + 4'd1, 4'd0} : {s10_q, s1_q + 4'd1};
    assign sec_dn = sec_zero ? 8'h59 : (s1_q == 4'd0) ? {s10_q - 4'd1, 4'd9} : {s10_q, s1_q - 4'd1};
    assign min_up = min_at_max ? 8'h00 : (m1_q == 4'd9) ? {m10_q + 4'd1, 4'd0} : {m10_q, m1_q + 4'd1};
    assign min_dn = (m1_q == 4'd0) ? {m10_q - 4'd1, 4'd9} : {m10_q, m1_q - 4'd1};

    always_comb begin
        state_d = state_q;
        m10_d   = m10_q;
        m1_d    = m1_q;
        s10_d   = s10_q;
        s1_d    = s1_q;
        if (clr_ev) begin
            state_d = ST_STOPPED;
            m10_d   = 4'd0;
            m1_d    = 4'd0;
            s10_d   = 4'd0;
            s1_d    = 4'd0;
        end else if (ss_ev) begin
            if (state_q == ST_STOPPED) begin
                if (!(mode && cnt_zero)) state_d = ST_RUN;
            end else begin
                state_d = ST_STOPPED;
            end
        end else if (tick && state_q == ST_RUN) begin
            if (!mode) begin
                if (cnt_max) begin
                    state_d = ST_DONE;
                end else begin
                    {s10_d, s1_d} = sec_up;
                    if (sec_wrap) {m10_d, m1_d} = min_up;
                end
            end else if (cnt_zero) begin
                state_d = ST_DONE;
            end else begin
                {s10_d, s1_d} = sec_dn;
                if (sec_zero) {m10_d, m1_d} = min_dn;
                if (cnt_one) state_d = ST_DONE;
            end
        end else if (state_q == ST_STOPPED) begin
            if (isec_ev) {s10_d, s1_d} = sec_up;
            if (imin_ev) {m10_d, m1_d} = min_up;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_STOPPED;
            m10_q       <= 4'd0;
            m1_q        <= 4'd0;
            s10_q       <= 4'd0;
            s1_q        <= 4'd0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            armed_q     <= 1'b0;
            clr_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b0;
            imin_prev_q <= 1'b0;
            isec_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m10_q       <= m10_d;
            m1_q        <= m1_d;
            s10_q       <= s10_d;
            s1_q        <= s1_d;
            running_q   <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
            armed_q     <= 1'b1;
            clr_prev_q  <= clr;
            ss_prev_q   <= start_stop;
            imin_prev_q <= inc_min;
            isec_prev_q <= inc_sec;
        end
    end

`ifdef TIMER_ALARM_EN
    localparam int AW = $clog2(ALARM_TICKS + 1);
    logic [AW-1:0] alarm_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_cnt_q <= '0;
        end else if (clr_ev || ss_ev) begin
            alarm_cnt_q <= '0;
        end else if (state_q != ST_DONE && state_d == ST_DONE) begin
            alarm_cnt_q <= AW'(ALARM_TICKS);
        end else if (tick && alarm_cnt_q != '0) begin
            alarm_cnt_q <= alarm_cnt_q - 1'b1;
        end
    end

    assign alarm = (alarm_cnt_q != '0);
`else
    assign alarm = 1'b0 & (ALARM_TICKS != 0);
`endif

    assign m10     = m10_q;
    assign m1      = m1_q;
    assign s10     = s10_q;
    assign s1      = s1_q;
    assign running = running_q;
    assign done    = done_q;
endmodule

// File: tb/tb_mmss_bcd_counter.sv
// tb/tb_mmss_bcd_counter.sv - randomized and directed check of mmss_bcd_counter against a seconds-based model
module tb_mmss_bcd_counter;
    localparam int MIN_MAX     = 59;
    localparam int ALARM_TICKS = 5;

    logic       clk = 1'b0;
    logic       rst_n, tick, mode, clr, start_stop, inc_min, inc_sec;
    logic [3:0] m10, m1, s10, s1;
    logic       running, done, alarm;

    int n_checks = 0;
    int n_fail   = 0;

    // model: minutes/seconds as integers, state 0=stopped 1=run 2=done
    int mins, secs, st, alarm_left;
    bit armed, p_clr, p_ss, p_im, p_is;
    bit mode_lv, b_clr, b_ss, b_im, b_is;

    mmss_bcd_counter #(.MIN_MAX(MIN_MAX), .ALARM_TICKS(ALARM_TICKS)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode), .clr(clr),
        .start_stop(start_stop), .inc_min(inc_min), .inc_sec(inc_sec),
        .m10(m10), .m1(m1), .s10(s10), .s1(s1),
        .running(running), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_digits();
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
    endfunction

    function automatic bit model_alarm();
`ifdef TIMER_ALARM_EN
        return alarm_left > 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        mins = 0; secs = 0; st = 0; alarm_left = 0;
        armed = 0; p_clr = 0; p_ss = 0; p_im = 0; p_is = 0;
    endfunction

    function automatic void enter_done();
        st = 2;
        alarm_left = ALARM_TICKS;
    endfunction

    function automatic void model_step(input bit t, input bit md, input bit c, input bit ss, input bit im, input bit is);
        bit e_c, e_ss, e_im, e_is;
        int total;
        e_c  = armed && c  && !p_clr;
        e_ss = armed && ss && !p_ss;
        e_im = armed && im && !p_im;
        e_is = armed && is && !p_is;
        p_clr = c; p_ss = ss; p_im = im; p_is = is; armed = 1;
        total = mins * 60 + secs;
        if (e_c) begin
            mins = 0; secs = 0; st = 0; alarm_left = 0;
        end else if (e_ss) begin
            alarm_left = 0;
            if (st == 0) begin
                if (!(md && total == 0)) st = 1;
            end else begin
                st = 0;
            end
        end else if (t && st == 1) begin
            if (!md) begin
                if (total == MIN_MAX * 60 + 59) enter_done();
                else total = total + 1;
            end else if (total == 0) begin
                enter_done();
            end else begin
                total = total - 1;
                if (total == 0) enter_done();
            end
            mins = total / 60;
            secs = total % 60;
        end else if (t && st == 2) begin
            if (alarm_left > 0) alarm_left = alarm_left - 1;
        end else if (st == 0) begin
            if (e_is) secs = (secs + 1) % 60;
            if (e_im) mins = (mins == MIN_MAX) ? 0 : mins + 1;
        end
    endfunction

    task automatic compare_model();
        n_checks++;
        if ({m10, m1, s10, s1} !== model_digits() || running !== (st == 1) ||
            done !== (st == 2) || alarm !== model_alarm()) begin
            n_fail++;
            $display("FAIL cycle_compare @%0t: got %h run=%b done=%b alarm=%b, expected %h run=%0d done=%0d alarm=%0d",
                     $time, {m10, m1, s10, s1}, running, done, alarm, model_digits(), st == 1, st == 2, model_alarm());
        end
    endtask

    task automatic check_lit(input string name, input logic [15:0] d, input bit r, input bit dn);
        n_checks++;
        if ({m10, m1, s10, s1} !== d || running !== r || done !== dn) begin
            n_fail++;
            $display("FAIL %s dut: got %h run=%b done=%b, expected %h run=%b done=%b",
                     name, {m10, m1, s10, s1}, running, done, d, r, dn);
        end
        n_checks++;
        if (model_digits() !== d || (st == 1) !== r || (st == 2) !== dn) begin
            n_fail++;
            $display("FAIL %s model: got %h st=%0d, expected %h run=%b done=%b", name, model_digits(), st, d, r, dn);
        end
    endtask

    task automatic check_alarm(input string name, input bit a);
        n_checks++;
        if (alarm !== a) begin
            n_fail++;
            $display("FAIL %s: got alarm=%b, expected %b", name, alarm, a);
        end
    endtask

    task automatic cycle(input bit t, input bit c, input bit ss, input bit im, input bit is);
        tick = t; mode = mode_lv; clr = c; start_stop = ss; inc_min = im; inc_sec = is;
        @(posedge clk);
        model_step(t, mode_lv, c, ss, im, is);
        @(negedge clk);
        compare_model();
    endtask

    // which: 0=clr 1=start_stop 2=inc_min 3=inc_sec
    task automatic press(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, which == 0, which == 1, which == 2, which == 3);
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; mode = 1'b0; clr = 1'b0;
        start_stop = 1'b1; inc_min = 1'b0; inc_sec = 1'b0;
        mode_lv = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_lit("reset_state", 16'h0000, 1'b0, 1'b0);
        check_alarm("reset_alarm", 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_lit("held_ss_no_event", 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        press(1, 1);
        ticks(61);
        check_lit("up_61_ticks", 16'h0101, 1'b1, 1'b0);
        press(1, 1);
        press(0, 1);
        press(2, 9);
        press(3, 59);
        check_lit("preload_0959", 16'h0959, 1'b0, 1'b0);
        press(1, 1);
        ticks(1);
        check_lit("carry_1000", 16'h1000, 1'b1, 1'b0);
        press(1, 1);

        press(0, 1);
        press(3, 59);
        press(3, 1);
        check_lit("sec_wrap", 16'h0000, 1'b0, 1'b0);
        press(2, 59);
        check_lit("min_at_max", 16'h5900, 1'b0, 1'b0);
        press(2, 1);
        check_lit("min_wrap", 16'h0000, 1'b0, 1'b0);

        mode_lv = 1'b1;
        press(1, 1);
        check_lit("zero_start_guard", 16'h0000, 1'b0, 1'b0);
        press(3, 3);
        press(1, 1);
        ticks(2);
        check_lit("down_0001", 16'h0001, 1'b1, 1'b0);
        ticks(1);
        check_lit("down_expiry", 16'h0000, 1'b0, 1'b1);
`ifdef TIMER_ALARM_EN
        check_alarm("alarm_on_entry", 1'b1);
        ticks(ALARM_TICKS - 1);
        check_alarm("alarm_last_tick", 1'b1);
        ticks(1);
        check_alarm("alarm_expired", 1'b0);
`else
        ticks(ALARM_TICKS);
        check_alarm("alarm_disabled", 1'b0);
`endif
        check_lit("done_holds", 16'h0000, 1'b0, 1'b1);
        press(1, 1);
        check_lit("done_ack", 16'h0000, 1'b0, 1'b0);

        mode_lv = 1'b0;
        press(1, 1);
        press(2, 3);
        check_lit("inc_min_in_run", 16'h0000, 1'b1, 1'b0);
        ticks(3);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_lit("clr_ss_tick", 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        press(1, 1);
        ticks(2);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_lit("ss_drops_tick", 16'h0002, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        press(0, 1);
        press(2, 59);
        press(3, 58);
        press(1, 1);
        ticks(1);
        check_lit("up_5959", 16'h5959, 1'b1, 1'b0);
        ticks(1);
        check_lit("up_max_done", 16'h5959, 1'b0, 1'b1);
        press(1, 1);

        press(0, 1);
        press(2, 12);
        press(3, 34);
        press(1, 1);
        check_lit("run_1234", 16'h1234, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_lit("async_reset", 16'h0000, 1'b0, 1'b0);
        check_alarm("async_reset_alarm", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        b_clr = 0; b_ss = 0; b_im = 0; b_is = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) b_clr = ~b_clr;
            if ($urandom_range(0, 11) == 0) b_ss = ~b_ss;
            if ($urandom_range(0, 3) == 0)  b_im = ~b_im;
            if ($urandom_range(0, 2) == 0)  b_is = ~b_is;
            if ($urandom_range(0, 79) == 0) mode_lv = ~mode_lv;
            cycle($urandom_range(0, 1) == 1, b_clr, b_ss, b_im, b_is);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
